timer_arbiter: RTL
==================

# timer_arbiter

Round-robin arbiter and sequencer that shares one 4-bit interval timer between two requesters. Each requester asks for a timed interval of `dur` clock cycles. The block grants the timer to one requester at a time, loads and runs its internal up-counter, and returns a one-cycle `done` pulse to the granted requester. It sits between the control logic that needs timed waits and the shared loadable counter datapath.

## Interface
Parameters
- `WIDTH`, default 4: counter and duration width.

Ports
- `clk`, input, 1: single clock; all logic is rising-edge.
- `clr`, input, 1: reset; synchronous, active-high.
- `req0`, input, 1: requester 0 asks for an interval; held high until `done0`.
- `dur0`, input, WIDTH: requester 0 interval length in cycles; sampled at grant.
- `req1`, input, 1: requester 1 request; same rules as `req0`.
- `dur1`, input, WIDTH: requester 1 interval length in cycles.
- `gnt0`, output, 1: timer owned by requester 0 (LOAD, RUN, DONE).
- `gnt1`, output, 1: timer owned by requester 1.
- `done0`, output, 1: one-cycle pulse; requester 0 interval complete.
- `done1`, output, 1: one-cycle pulse; requester 1 interval complete.
- `busy`, output, 1: state is not IDLE.
- `q`, output, WIDTH: current counter value.

## Operation
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- Internal registers:
  - `state`: IDLE, LOAD, RUN, DONE.
  - `owner`: 1 bit.
  - `prio`: 1 bit; the requester that wins a tie.
  - `dur_l`: WIDTH bits.
  - `q`: WIDTH bits.
- `clr` forces on the next edge: state=IDLE, owner=0, prio=0, dur_l=0, q=0. All outputs are then 0. `clr` overrides every other event, including reset mid-RUN.
- **IDLE**
  - No request: stay in IDLE; q holds its last value.
  - Exactly one request: grant it.
  - Both requesting: grant `prio`.
  - On grant: owner ← winner; dur_l ← winner's dur; go to LOAD.
- **LOAD**
  - q ← 0.
  - If dur_l == 0, go to DONE; otherwise go to RUN.
- **RUN**
  - q ← q+1 each cycle.
  - When q+1 == dur_l, go to DONE.
  - q saturates at dur_l; it never wraps inside an interval. Maximum dur is 2^WIDTH−1 (15 for the default WIDTH), giving a final q of 15.
- **DONE**
  - done[owner] = 1 for exactly this cycle.
  - prio ← ~owner.
  - Go to IDLE.
- **Abort:** if req[owner] is low in LOAD or RUN:
  - go to IDLE on the next edge;
  - no done pulse;
  - q holds;
  - prio ← ~owner.
- req[owner] low during DONE is ignored; done still pulses.
- Non-owner requests are ignored until the next IDLE. There is no preemption.
- dur changes after the grant are ignored, because dur_l is latched.
- gnt[owner] = 1 in LOAD, RUN and DONE. gnt0 and gnt1 are never high together.

## Timing
- Request sampled high in IDLE in cycle c:
  - gnt high in c+1 (LOAD);
  - q=0 in c+2;
  - done in cycle c+2+dur, with q=dur;
  - IDLE again in c+3+dur.
- Edge cases:
  - dur=0: gnt in c+1, done in c+2, q=0.
  - dur=15: done in c+17, q=15.
- Back-to-back requests: the minimum spacing between consecutive grants is dur+3 cycles. One IDLE cycle always separates intervals.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1…, starting with 0 after `clr`.
- Reset latency: outputs read 0 in the first cycle after the `clr` edge.

## Test plan
- **Reset:** drive `clr`=1 for 2 cycles with req0=req1=1 → gnt0=gnt1=done0=done1=busy=0, q=0. Release `clr` → gnt0 rises first.
- **Single interval:** req0=1, dur0=3 sampled in cycle c → gnt0 in c+1; q=0,1,2 in c+2..c+4; done0 and q=3 in c+5; busy=0 in c+6.
- **Zero and maximum duration:**
  - dur1=0 → done1 two cycles after the request is sampled, q=0.
  - dur1=15 → done1 17 cycles after, q=15, with no wrap.
- **Contention:** req0=req1=1 held continuously, dur0=2, dur1=1 → grant order 0,1,0,1. Check each done in its owner's slot only, and that gnt0 and gnt1 are never both high.
- **Abort:** req0 drops in the second RUN cycle (dur0=5) → next cycle IDLE, gnt0=0, no done0, q holds 1. A pending req1 is then granted.
- **Reset mid-RUN:** `clr` asserted in RUN with q=4 → next cycle state IDLE, q=0, no done pulse, prio=0.

Source files
------------

// File: rtl/timer_arbiter.sv
// ============================================================================
// Module   : timer_arbiter
// Purpose  : Round-robin arbiter sharing one loadable interval up-counter
//            between two requesters; one-cycle done pulse per interval.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic [WIDTH-1:0] dur0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dur1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_prio;
    logic [WIDTH-1:0] r_dur_l;
    logic [WIDTH-1:0] r_q;

    logic             w_req_own;
    logic             w_win;
    logic [WIDTH-1:0] w_q_inc;

    assign w_req_own = r_owner ? req1 : req0;
    // With a single requester it wins outright; a tie goes to the priority holder.
    assign w_win     = (req0 && req1) ? r_prio : req1;
    assign w_q_inc   = r_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_dur_l <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner <= w_win;
                        r_dur_l <= w_win ? dur1 : dur0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_req_own) begin
                        r_prio  <= ~r_owner;
                        r_state <= S_IDLE;
                    end else begin
                        r_q     <= '0;
                        r_state <= (r_dur_l == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_req_own) begin
                        r_prio  <= ~r_owner;
                        r_state <= S_IDLE;
                    end else begin
                        // Leaving on q+1 == dur_l keeps q from ever passing dur_l.
                        r_q <= w_q_inc;
                        if (w_q_inc == r_dur_l) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_prio  <= ~r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign gnt0  = busy && !r_owner;
    assign gnt1  = busy &&  r_owner;
    assign done0 = (r_state == S_DONE) && !r_owner;
    assign done1 = (r_state == S_DONE) &&  r_owner;
    assign q     = r_q;

endmodule

`default_nettype wire
